// File: rtl/trigger_source_arbiter_if.sv
// Trigger arbiter bus: raw trigger/control inputs and accepted-trigger/scaler outputs.
// The arbiter uses the slave side; the driver of the triggers uses the master side.
interface trigger_source_arbiter_if #(
    parameter int NUM_SRC   = 4,
    parameter int HOLDOFF_W = 8,
    parameter int CNT_W     = 16,
    parameter int SEL_W     = 2
);
    logic [NUM_SRC-1:0]   trig_i;
    logic [NUM_SRC-1:0]   en_i;
    logic [HOLDOFF_W-1:0] holdoff_i;
    logic                 busy_i;
    logic                 pps_i;
    logic                 clr_i;
    logic [SEL_W-1:0]     scal_addr_i;
    logic                 trig_o;
    logic [NUM_SRC-1:0]   trig_src_o;
    logic [CNT_W-1:0]     scal_dat_o;
    logic [CNT_W-1:0]     dropped_o;
    logic                 holdoff_o;

    modport slave (
        input  trig_i, en_i, holdoff_i, busy_i, pps_i, clr_i, scal_addr_i,
        output trig_o, trig_src_o, scal_dat_o, dropped_o, holdoff_o
    );

    modport master (
        output trig_i, en_i, holdoff_i, busy_i, pps_i, clr_i, scal_addr_i,
        input  trig_o, trig_src_o, scal_dat_o, dropped_o, holdoff_o
    );
endinterface

// File: rtl/trigger_source_arbiter.sv
// Trigger source arbiter: synchronises raw trigger levels, merges coincident edges into one
// accepted pulse, applies a programmable deadtime, and keeps per-second scalers and a drop count.
module trigger_source_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int HOLDOFF_W = 8,
    parameter int CNT_W     = 16,
    parameter int SEL_W     = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    trigger_source_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0]     CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]       CNT_INC  = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [HOLDOFF_W-1:0] HOLD_ONE = {{(HOLDOFF_W-1){1'b0}}, 1'b1};
    localparam logic [HOLDOFF_W-1:0] HOLD_ZRO = {HOLDOFF_W{1'b0}};

    // Number of set bits, widened so it can be added straight onto a counter.
    function automatic logic [CNT_W:0] count_ones(input logic [NUM_SRC-1:0] v);
        logic [CNT_W:0] n;
        n = {(CNT_W+1){1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            n = n + {{CNT_W{1'b0}}, v[k]};
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W:0]   b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + b;
        return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    logic [NUM_SRC-1:0]   sync1_q, sync1_d;
    logic [NUM_SRC-1:0]   sync2_q, sync2_d;
    logic [NUM_SRC-1:0]   dly_q, dly_d;
    state_e               state_q, state_d;
    logic [HOLDOFF_W-1:0] hcnt_q, hcnt_d;
    logic                 trig_q, trig_d;
    logic [NUM_SRC-1:0]   trig_src_q, trig_src_d;
    logic [CNT_W-1:0]     drop_q, drop_d;
    logic [CNT_W-1:0]     scal_q, scal_d;
    logic [CNT_W-1:0]     run_q [NUM_SRC];
    logic [CNT_W-1:0]     run_d [NUM_SRC];
    logic [CNT_W-1:0]     lat_q [NUM_SRC];
    logic [CNT_W-1:0]     lat_d [NUM_SRC];

    logic [NUM_SRC-1:0]   req_s;
    logic [NUM_SRC-1:0]   mreq_s;
    logic                 accept_s;

    assign req_s  = sync2_q & ~dly_q;
    assign mreq_s = req_s & bus.en_i;

    // Next-state logic: synchronizers, arbitration FSM, drop counter and scalers.
    always_comb begin
        sync1_d    = bus.trig_i;
        sync2_d    = sync1_q;
        dly_d      = sync2_q;
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        trig_d     = 1'b0;
        trig_src_d = {NUM_SRC{1'b0}};
        drop_d     = drop_q;
        accept_s   = 1'b0;
        run_d      = run_q;
        lat_d      = lat_q;
        scal_d     = {CNT_W{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            scal_d = (bus.scal_addr_i == SEL_W'(k)) ? lat_q[k] : scal_d;
        end

        if (bus.clr_i) begin
            // Clear wins over everything; the synchronizer chain keeps tracking trig_i.
            state_d = ST_IDLE;
            hcnt_d  = HOLD_ZRO;
            drop_d  = {CNT_W{1'b0}};
            scal_d  = {CNT_W{1'b0}};
            for (int k = 0; k < NUM_SRC; k++) begin
                run_d[k] = {CNT_W{1'b0}};
                lat_d[k] = {CNT_W{1'b0}};
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if ((mreq_s != {NUM_SRC{1'b0}}) && !bus.busy_i) begin
                        accept_s   = 1'b1;
                        trig_d     = 1'b1;
                        trig_src_d = mreq_s;
                        if (bus.holdoff_i != HOLD_ZRO) begin
                            state_d = ST_HOLD;
                            hcnt_d  = bus.holdoff_i;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        drop_d = sat_add(drop_q, count_ones(mreq_s));
                    end
                end
                ST_HOLD: begin
                    drop_d = sat_add(drop_q, count_ones(mreq_s));
                    hcnt_d = hcnt_q - HOLD_ONE;
                    if (hcnt_q == HOLD_ONE) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hcnt_d  = HOLD_ZRO;
                end
            endcase

            // A PPS snapshot still credits a trigger accepted in the same cycle to the new second.
            for (int k = 0; k < NUM_SRC; k++) begin
                if (bus.pps_i) begin
                    lat_d[k] = run_q[k];
                    run_d[k] = (accept_s && mreq_s[k]) ? CNT_INC[CNT_W-1:0] : {CNT_W{1'b0}};
                end else if (accept_s && mreq_s[k]) begin
                    run_d[k] = sat_add(run_q[k], CNT_INC);
                end else begin
                    run_d[k] = run_q[k];
                end
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q    <= {NUM_SRC{1'b0}};
            sync2_q    <= {NUM_SRC{1'b0}};
            dly_q      <= {NUM_SRC{1'b0}};
            state_q    <= ST_IDLE;
            hcnt_q     <= HOLD_ZRO;
            trig_q     <= 1'b0;
            trig_src_q <= {NUM_SRC{1'b0}};
            drop_q     <= {CNT_W{1'b0}};
            scal_q     <= {CNT_W{1'b0}};
            for (int k = 0; k < NUM_SRC; k++) begin
                run_q[k] <= {CNT_W{1'b0}};
                lat_q[k] <= {CNT_W{1'b0}};
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            dly_q      <= dly_d;
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            trig_q     <= trig_d;
            trig_src_q <= trig_src_d;
            drop_q     <= drop_d;
            scal_q     <= scal_d;
            for (int k = 0; k < NUM_SRC; k++) begin
                run_q[k] <= run_d[k];
                lat_q[k] <= lat_d[k];
            end
        end
    end

    assign bus.trig_o     = trig_q;
    assign bus.trig_src_o = trig_src_q;
    assign bus.scal_dat_o = scal_q;
    assign bus.dropped_o  = drop_q;
    assign bus.holdoff_o  = (state_q == ST_HOLD);

endmodule

// File: tb/tb_trigger_source_arbiter.sv
// Scoreboard bench for trigger_source_arbiter: a reference model predicts accepted triggers
// (queued for an independent monitor) plus drop count, holdoff flag and scaler readback.
module tb_trigger_source_arbiter;
    localparam int NUM_SRC   = 4;
    localparam int HOLDOFF_W = 8;
    localparam int CNT_W     = 4;
    localparam int SEL_W     = 3;
    localparam int CMAX      = (1 << CNT_W) - 1;

    typedef struct {
        int               c;
        logic [NUM_SRC-1:0] m;
    } exp_t;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    always #15 clk_i = ~clk_i;

    trigger_source_arbiter_if #(.NUM_SRC(NUM_SRC), .HOLDOFF_W(HOLDOFF_W),
                                .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

    trigger_source_arbiter #(.NUM_SRC(NUM_SRC), .HOLDOFF_W(HOLDOFF_W),
                             .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // stimulus applied for the next edge
    logic [NUM_SRC-1:0] d_trig, d_en;
    int d_hold, d_addr;
    bit d_busy, d_pps, d_clr;

    // reference model: trig history sampled per edge, newest first
    logic [NUM_SRC-1:0] hist [4];
    int remaining, drop_m, scal_m;
    int run_m [NUM_SRC];
    int lat_m [NUM_SRC];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Monitor: every trig_o pulse must match the oldest queued prediction.
    always @(negedge clk_i) begin
        while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missed_trig: no trig_o at cycle %0d, expected mask %b", exp_q[0].c, exp_q[0].m);
            void'(exp_q.pop_front());
        end
        if (bus.trig_o === 1'b1) begin
            if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                mon_e = exp_q.pop_front();
                check("trig_src", int'(bus.trig_src_o), int'(mon_e.m));
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_trig: trig_o=1 src=%b at cycle %0d, expected none", bus.trig_src_o, cyc);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) hist[i] = '0;
        remaining = 0;
        drop_m    = 0;
        scal_m    = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            run_m[k] = 0;
            lat_m[k] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [NUM_SRC-1:0] req, mreq;
        bit acc;
        int nscal;
        exp_t e;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = d_trig;
        req   = hist[2] & ~hist[3];
        nscal = 0;
        if (d_addr < NUM_SRC) nscal = lat_m[d_addr];
        acc = 1'b0;
        if (d_clr) begin
            remaining = 0;
            drop_m    = 0;
            nscal     = 0;
            for (int k = 0; k < NUM_SRC; k++) begin
                run_m[k] = 0;
                lat_m[k] = 0;
            end
        end else begin
            mreq = req & d_en;
            if (remaining == 0 && mreq != '0 && !d_busy) begin
                acc = 1'b1;
                e.c = cyc + 1;
                e.m = mreq;
                exp_q.push_back(e);
                remaining = d_hold;
            end else begin
                if (remaining > 0) remaining--;
                drop_m = sat(drop_m + $countones(mreq));
            end
            for (int k = 0; k < NUM_SRC; k++) begin
                if (d_pps) begin
                    lat_m[k] = run_m[k];
                    run_m[k] = (acc && mreq[k]) ? 1 : 0;
                end else if (acc && mreq[k]) begin
                    run_m[k] = sat(run_m[k] + 1);
                end
            end
        end
        scal_m = nscal;
    endtask

    task automatic step();
        @(negedge clk_i);
        #1;
        check("dropped", int'(bus.dropped_o), drop_m);
        check("holdoff", int'(bus.holdoff_o), (remaining > 0) ? 1 : 0);
        check("scal_dat", int'(bus.scal_dat_o), scal_m);
        rst_n_i         = 1'b1;
        bus.trig_i      = d_trig;
        bus.en_i        = d_en;
        bus.holdoff_i   = HOLDOFF_W'(d_hold);
        bus.busy_i      = d_busy;
        bus.pps_i       = d_pps;
        bus.clr_i       = d_clr;
        bus.scal_addr_i = SEL_W'(d_addr);
        model_step();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic apply_reset(input int ncyc);
        @(negedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        check("rst_trig_o", int'(bus.trig_o), 0);
        check("rst_trig_src", int'(bus.trig_src_o), 0);
        check("rst_scal", int'(bus.scal_dat_o), 0);
        check("rst_dropped", int'(bus.dropped_o), 0);
        check("rst_holdoff", int'(bus.holdoff_o), 0);
        model_reset();
        bus.trig_i = d_trig;
        repeat (ncyc) @(posedge clk_i);
    endtask

    task automatic pulse(input logic [NUM_SRC-1:0] m);
        d_trig = m;
        step();
        d_trig = '0;
        step();
    endtask

    initial begin
        int tc, hc, lat_j;
        d_trig = '0; d_en = '1; d_hold = 0; d_addr = 0;
        d_busy = 1'b0; d_pps = 1'b0; d_clr = 1'b0;
        bus.trig_i = '0; bus.en_i = '1; bus.holdoff_i = '0; bus.busy_i = 1'b0;
        bus.pps_i = 1'b0; bus.clr_i = 1'b0; bus.scal_addr_i = '0;
        model_reset();
        apply_reset(2);
        run(4);

        // single edge on bit 2, holdoff 5
        d_hold = 5;
        d_trig = 4'b0100;
        step();
        d_trig = '0;
        tc = 0; hc = 0; lat_j = 0;
        for (int j = 1; j <= 12; j++) begin
            step();
            if (bus.trig_o === 1'b1 && lat_j == 0) lat_j = j;
            tc += int'(bus.trig_o);
            hc += int'(bus.holdoff_o);
        end
        check("single_trig_count", tc, 1);
        check("single_latency", lat_j, 3);
        check("single_holdoff_len", hc, 5);

        // coincident edges on bits 0 and 3, then bit 1 inside the holdoff
        d_clr = 1'b1; step(); d_clr = 1'b0;
        d_trig = 4'b1001; step();
        d_trig = '0;      step();
        d_trig = 4'b0010; step();
        d_trig = '0;      run(10);
        check("coinc_drop", int'(bus.dropped_o), 1);

        // busy drop, then disabled source ignored
        d_clr = 1'b1; step(); d_clr = 1'b0;
        d_busy = 1'b1;
        pulse(4'b0001);
        run(4);
        d_busy = 1'b0;
        check("busy_drop", int'(bus.dropped_o), 1);
        d_en = 4'b1101;
        d_trig = 4'b0010; step();
        d_trig = '0;
        tc = 0;
        repeat (6) begin
            step();
            tc += int'(bus.trig_o);
        end
        check("disabled_no_trig", tc, 0);
        check("disabled_no_drop", int'(bus.dropped_o), 1);
        d_en = '1;

        // scalers: 7 accepts on bit 2, pps, readback
        d_clr = 1'b1; step(); d_clr = 1'b0;
        d_hold = 0;
        repeat (7) pulse(4'b0100);
        run(3);
        d_pps = 1'b1; step(); d_pps = 1'b0;
        d_addr = 2;
        run(2);
        check("scal_seven", int'(bus.scal_dat_o), 7);
        d_trig = 4'b0100; step();
        d_trig = '0;      step();
        d_pps = 1'b1;     step();
        d_pps = 1'b0;     run(3);
        d_pps = 1'b1;     step();
        d_pps = 1'b0;     run(2);
        check("scal_restart_one", int'(bus.scal_dat_o), 1);
        d_addr = 5;
        run(2);
        check("scal_addr_oob", int'(bus.scal_dat_o), 0);
        d_addr = 2;
        d_pps = 1'b1; step(); d_pps = 1'b0;
        pulse(4'b0100);
        run(2);
        d_pps = 1'b1; step(); d_pps = 1'b0;
        run(2);

        // drop saturation then clear
        d_busy = 1'b1;
        repeat (20) pulse(4'b0001);
        run(3);
        check("drop_saturate", int'(bus.dropped_o), CMAX);
        check("scal_before_clr", int'(bus.scal_dat_o), 1);
        d_busy = 1'b0;
        d_clr = 1'b1; step(); d_clr = 1'b0;
        step();
        check("clr_dropped", int'(bus.dropped_o), 0);
        check("clr_scal", int'(bus.scal_dat_o), 0);

        // reset in the middle of a long holdoff
        d_hold = 50;
        d_trig = 4'b1000; step();
        d_trig = '0;
        run(6);
        check("in_hold", int'(bus.holdoff_o), 1);
        apply_reset(2);
        tc = 0;
        repeat (60) begin
            step();
            tc += int'(bus.trig_o);
        end
        check("post_reset_no_trig", tc, 0);

        // trig level held through reset release gives exactly one trigger
        d_hold = 3;
        d_trig = 4'b0100;
        apply_reset(2);
        tc = 0;
        repeat (8) begin
            step();
            tc += int'(bus.trig_o);
        end
        check("held_across_reset", tc, 1);
        d_trig = '0;
        run(4);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            d_trig = d_trig ^ (NUM_SRC'($urandom_range(0, 15)) & NUM_SRC'($urandom_range(0, 15)));
            d_en   = ($urandom_range(0, 7) != 0) ? 4'b1111 : NUM_SRC'($urandom_range(0, 15));
            d_hold = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
            d_busy = ($urandom_range(0, 5) == 0);
            d_pps  = ($urandom_range(0, 39) == 0);
            d_clr  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) d_addr = int'($urandom_range(0, 7));
            step();
        end
        d_trig = '0; d_busy = 1'b0; d_pps = 1'b0; d_clr = 1'b0;
        run(10);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
